// File: rtl/vga_fb.sv
// vga_fb: double-buffered framebuffer with a registered front-bank read,
// a valid/ready back-bank write port, a clear engine and a frame-end swap.
// Ports:
//   clk, resetn        clock, async active-low reset
//   rd_en/rd_h/rd_v    display read request; rd_data appears 1 cycle later
//   frame_end          end-of-visible-frame strobe; gates bank swaps
//   wr_valid/wr_ready  producer handshake; wr_h/wr_v/wr_data give the pixel
//   wr_oob             sticky flag: an out-of-range write was dropped
//   swap_req           request swap; swap_pending/front_bank/frame_cnt report it
//   clr_req/clr_color  fill the back bank; clr_busy is high while filling
module vga_fb #(
  parameter int H_BITS   = 10,
  parameter int V_BITS   = 9,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int PIX_W    = 24
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rd_en,
  input  logic [H_BITS-1:0] rd_h,
  input  logic [V_BITS-1:0] rd_v,
  output logic [PIX_W-1:0]  rd_data,
  input  logic              frame_end,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [H_BITS-1:0] wr_h,
  input  logic [V_BITS-1:0] wr_v,
  input  logic [PIX_W-1:0]  wr_data,
  output logic              wr_oob,
  input  logic              swap_req,
  output logic              swap_pending,
  output logic              front_bank,
  input  logic              clr_req,
  input  logic [PIX_W-1:0]  clr_color,
  output logic              clr_busy,
  output logic [7:0]        frame_cnt
);

  localparam int AW = 1 + V_BITS + H_BITS;
  localparam logic [H_BITS:0] H_MAX  = H_ACTIVE[H_BITS:0];
  localparam logic [V_BITS:0] V_MAX  = V_ACTIVE[V_BITS:0];
  localparam logic [H_BITS:0] H_LAST = H_MAX - 1'b1;
  localparam logic [V_BITS:0] V_LAST = V_MAX - 1'b1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t state, state_nx;

  logic [PIX_W-1:0] mem [0:(1<<AW)-1];

  logic              tgt;
  logic [PIX_W-1:0]  color;
  logic [H_BITS-1:0] ch;
  logic [V_BITS-1:0] cv;

  logic rd_in, wr_in, wr_fire;
  logic swap_go, clr_start;
  logic ch_last, clr_last;

  logic             mem_we;
  logic [AW-1:0]    mem_wa;
  logic [PIX_W-1:0] mem_wd;

  assign rd_in = ({1'b0, rd_h} < H_MAX) &&
                 ({1'b0, rd_v} < V_MAX);
  assign wr_in = ({1'b0, wr_h} < H_MAX) &&
                 ({1'b0, wr_v} < V_MAX);

  assign ch_last  = ({1'b0, ch} == H_LAST);
  assign clr_last = ch_last &&
                    ({1'b0, cv} == V_LAST);

  assign wr_fire = wr_valid && wr_ready;

  // A swap never lands mid-clear, so a
  // half-filled bank is never displayed.
  assign swap_go = frame_end &&
                   (swap_pending || swap_req) &&
                   (state == IDLE);

  always_comb begin
    state_nx  = state;
    wr_ready  = 1'b0;
    clr_busy  = 1'b0;
    clr_start = 1'b0;
    mem_we    = 1'b0;
    mem_wa    = {~front_bank, wr_v, wr_h};
    mem_wd    = wr_data;
    unique case (state)
      IDLE: begin
        wr_ready  = !clr_req;
        clr_start = clr_req;
        mem_we    = wr_valid && !clr_req && wr_in;
        if (clr_req)
          state_nx = CLEAR;
      end
      CLEAR: begin
        clr_busy = 1'b1;
        mem_we   = 1'b1;
        mem_wa   = {tgt, cv, ch};
        mem_wd   = color;
        if (clr_last)
          state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      front_bank   <= 1'b0;
      swap_pending <= 1'b0;
      frame_cnt    <= 8'd0;
      wr_oob       <= 1'b0;
      tgt          <= 1'b0;
      color        <= '0;
      ch           <= '0;
      cv           <= '0;
    end else begin
      state <= state_nx;
      if (wr_fire && !wr_in)
        wr_oob <= 1'b1;
      if (swap_go) begin
        front_bank   <= ~front_bank;
        swap_pending <= 1'b0;
        frame_cnt    <= frame_cnt + 8'd1;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
      if (clr_start) begin
        tgt   <= ~front_bank;
        color <= clr_color;
        ch    <= '0;
        cv    <= '0;
      end else if (state == CLEAR) begin
        if (ch_last) begin
          ch <= '0;
          cv <= cv + 1'b1;
        end else begin
          ch <= ch + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      rd_data <= '0;
    else if (rd_en && rd_in)
      rd_data <= mem[{front_bank, rd_v, rd_h}];
    else
      rd_data <= '0;
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_wa] <= mem_wd;
  end

endmodule

// File: tb/tb_vga_fb.sv
// tb_vga_fb: randomized self-checking bench for vga_fb
// against a frame-level reference model of the two banks.
module tb_vga_fb;

  logic       clk = 1'b0;
  logic       resetn;
  logic       rd_en;
  logic [2:0] rd_h;
  logic [1:0] rd_v;
  logic [7:0] rd_data;
  logic       frame_end;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_h;
  logic [1:0] wr_v;
  logic [7:0] wr_data;
  logic       wr_oob;
  logic       swap_req;
  logic       swap_pending;
  logic       front_bank;
  logic       clr_req;
  logic [7:0] clr_color;
  logic       clr_busy;
  logic [7:0] frame_cnt;

  always #5 clk = ~clk;

  vga_fb #(
    .H_BITS(3), .V_BITS(2),
    .H_ACTIVE(6), .V_ACTIVE(3),
    .PIX_W(8)
  ) dut (
    .clk(clk), .resetn(resetn),
    .rd_en(rd_en), .rd_h(rd_h), .rd_v(rd_v),
    .rd_data(rd_data), .frame_end(frame_end),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_h(wr_h), .wr_v(wr_v), .wr_data(wr_data),
    .wr_oob(wr_oob), .swap_req(swap_req),
    .swap_pending(swap_pending),
    .front_bank(front_bank), .clr_req(clr_req),
    .clr_color(clr_color), .clr_busy(clr_busy),
    .frame_cnt(frame_cnt)
  );

  // reference model
  logic [7:0] m  [2][4][8];
  bit         kn [2][4][8];
  bit         fr, pd, oob;
  int         fc;
  int         cl_left;
  logic [7:0] cl_col;
  bit         cl_tgt;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic idle_in();
    rd_en = 0; rd_h = 0; rd_v = 0;
    frame_end = 0; wr_valid = 0;
    wr_h = 0; wr_v = 0; wr_data = 0;
    swap_req = 0; clr_req = 0;
    clr_color = 0;
  endtask

  task automatic step();
    logic [7:0] e_rd;
    bit rdk, busy, go;
    @(negedge clk);
    chk("wr_ready", wr_ready,
        (cl_left == 0) && !clr_req);
    @(posedge clk);
    rdk  = 1;
    e_rd = 8'h00;
    if (rd_en && rd_h < 6 && rd_v < 3) begin
      rdk  = kn[fr][rd_v][rd_h];
      e_rd = m[fr][rd_v][rd_h];
    end
    busy = (cl_left > 0);
    if (wr_valid && !busy && !clr_req) begin
      if (wr_h < 6 && wr_v < 3) begin
        m[!fr][wr_v][wr_h]  = wr_data;
        kn[!fr][wr_v][wr_h] = 1;
      end else begin
        oob = 1;
      end
    end
    go = frame_end && (pd || swap_req) && !busy;
    if (!busy && clr_req) begin
      cl_left = 18;
      cl_col  = clr_color;
      cl_tgt  = !fr;
    end else if (busy) begin
      cl_left--;
      if (cl_left == 0)
        for (int v = 0; v < 3; v++)
          for (int h = 0; h < 6; h++) begin
            m[cl_tgt][v][h]  = cl_col;
            kn[cl_tgt][v][h] = 1;
          end
    end
    if (go) begin
      fr = !fr; pd = 0; fc = (fc + 1) % 256;
    end else if (swap_req) begin
      pd = 1;
    end
    #1;
    if (rdk) chk("rd_data", rd_data, e_rd);
    chk("front_bank", front_bank, fr);
    chk("swap_pending", swap_pending, pd);
    chk("frame_cnt", frame_cnt, fc);
    chk("clr_busy", clr_busy, cl_left > 0);
    chk("wr_oob", wr_oob, oob);
  endtask

  task automatic do_reset();
    idle_in();
    resetn = 0;
    #1;
    if (cl_left > 0)
      for (int v = 0; v < 4; v++)
        for (int h = 0; h < 8; h++)
          kn[cl_tgt][v][h] = 0;
    fr = 0; pd = 0; oob = 0; fc = 0;
    cl_left = 0;
    chk("rst_busy", clr_busy, 0);
    chk("rst_pend", swap_pending, 0);
    chk("rst_front", front_bank, 0);
    chk("rst_rd", rd_data, 0);
    chk("rst_fcnt", frame_cnt, 0);
    chk("rst_oob", wr_oob, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1;
  endtask

  task automatic wr(input int h, input int v,
                    input logic [7:0] d);
    wr_valid = 1;
    wr_h = 3'(h); wr_v = 2'(v); wr_data = d;
    step();
    wr_valid = 0;
  endtask

  task automatic rd(input int h, input int v);
    rd_en = 1; rd_h = 3'(h); rd_v = 2'(v);
    step();
    rd_en = 0;
  endtask

  task automatic do_clear(input logic [7:0] c);
    int n;
    clr_req = 1; clr_color = c;
    step();
    clr_req = 0;
    n = 0;
    while (clr_busy === 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("clr_done", clr_busy, 0);
  endtask

  task automatic do_swap();
    swap_req = 1; frame_end = 1;
    step();
    swap_req = 0; frame_end = 0;
  endtask

  initial begin
    int n;
    logic [7:0] fc0;
    for (int b = 0; b < 2; b++)
      for (int v = 0; v < 4; v++)
        for (int h = 0; h < 8; h++)
          kn[b][v][h] = 0;
    cl_left = 0;
    do_reset();

    // write, swap, read back
    wr(2, 1, 8'hA5);
    swap_req = 1; step(); swap_req = 0;
    frame_end = 1; step(); frame_end = 0;
    chk("t1_front", front_bank, 1);
    chk("t1_fcnt", frame_cnt, 1);
    rd(2, 1);
    chk("t1_rd", rd_data, 8'hA5);
    step();
    chk("t1_rd_off", rd_data, 0);

    // clear with blocked writes and a
    // frame_end that must be deferred
    clr_req = 1; clr_color = 8'h3C;
    wr_valid = 1; wr_data = 8'hEE;
    step();
    clr_req = 0;
    n = 1;
    while (clr_busy === 1'b1 && n < 100) begin
      swap_req  = (n == 1);
      frame_end = (n == 4);
      step();
      if (clr_busy === 1'b1) n++;
    end
    wr_valid = 0; swap_req = 0;
    frame_end = 0;
    chk("t2_len", n, 18);
    chk("t4_pend", swap_pending, 1);
    chk("t4_front", front_bank, 1);
    frame_end = 1; step(); frame_end = 0;
    chk("t4_swap", front_bank, 0);
    chk("t4_pend0", swap_pending, 0);
    for (int v = 0; v < 3; v++)
      for (int h = 0; h < 6; h++) begin
        rd(h, v);
        chk("t2_fill", rd_data, 8'h3C);
      end

    // out-of-range writes
    wr(6, 0, 8'h11);
    wr(0, 3, 8'h22);
    chk("t3_oob", wr_oob, 1);
    rd(6, 0);
    chk("t3_rd", rd_data, 0);

    // merged swap requests; write in swap cycle
    fc0 = frame_cnt;
    repeat (3) begin
      swap_req = 1; step();
    end
    swap_req = 0;
    frame_end = 1;
    wr_valid = 1; wr_h = 1; wr_v = 1;
    wr_data = 8'h77;
    step();
    wr_valid = 0;
    step();
    frame_end = 0;
    chk("t5_fcnt", frame_cnt, fc0 + 8'd1);
    rd(1, 1);
    chk("t5_rd", rd_data, 8'h77);

    // make both banks known, then randomize
    do_clear(8'($urandom));
    do_swap();
    do_clear(8'($urandom));
    for (int i = 0; i < 600; i++) begin
      rd_en     = 1'($urandom_range(0, 1));
      rd_h      = 3'($urandom_range(0, 7));
      rd_v      = 2'($urandom_range(0, 3));
      wr_valid  = 1'($urandom_range(0, 1));
      wr_h      = 3'($urandom_range(0, 7));
      wr_v      = 2'($urandom_range(0, 3));
      wr_data   = 8'($urandom);
      swap_req  = ($urandom_range(0, 9) == 0);
      frame_end = ($urandom_range(0, 14) == 0);
      clr_req   = !frame_end &&
                  ($urandom_range(0, 49) == 0);
      clr_color = 8'($urandom);
      step();
    end
    idle_in();
    step();

    // reset mid-clear with a swap pending
    clr_req = 1; clr_color = 8'h5A;
    step();
    clr_req = 0;
    step();
    swap_req = 1; step(); swap_req = 0;
    step();
    rd_en = 1; rd_h = 0; rd_v = 0;
    step();
    chk("t6_pre", swap_pending, 1);
    do_reset();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_fb.md
Name: vga_fb

Overview:
Parametrised double-buffered VGA framebuffer, successor to the single-bank read-only picture memory behind vga_ctrl.
- Display side reads the front bank with a registered read, in step with vga_ctrl's h_addr/v_addr.
- Producer side writes pixels into the back bank through a valid/ready handshake.
- Includes a hardware clear engine and a swap that takes effect only at frame end.
- Sits between vga_ctrl and a drawing/keyboard-driven producer.

Parameters:
H_BITS, 10, width of horizontal coordinate
V_BITS, 9, width of vertical coordinate
H_ACTIVE, 640, visible pixels per line (must be <= 2^H_BITS)
V_ACTIVE, 480, visible lines (must be <= 2^V_BITS)
PIX_W, 24, pixel width (RGB888 by default)

Ports:
clk  in  1  system/pixel clock
resetn  in  1  asynchronous active-low reset
rd_en  in  1  display valid (vga_ctrl valid)
rd_h  in  H_BITS  display column
rd_v  in  V_BITS  display row
rd_data  out  PIX_W  front-bank pixel, 1-cycle latency
frame_end  in  1  one-cycle strobe at end of visible frame
wr_valid  in  1  producer write request
wr_ready  out  1  write accepted when wr_valid & wr_ready
wr_h  in  H_BITS  write column
wr_v  in  V_BITS  write row
wr_data  in  PIX_W  write pixel
wr_oob  out  1  sticky: an out-of-range write was dropped
swap_req  in  1  pulse: request bank swap
swap_pending  out  1  swap requested, not yet performed
front_bank  out  1  bank currently displayed
clr_req  in  1  pulse: fill back bank with clr_color
clr_color  in  PIX_W  fill value, sampled at clear start
clr_busy  out  1  clear in progress
frame_cnt  out  8  completed swaps, wraps 255->0

Behaviour:
Reset (resetn=0, async):
- front_bank=0, swap_pending=0, clr_busy=0, rd_data=0, wr_oob=0, frame_cnt=0, FSM=IDLE.
- Memory contents are not reset.

Memory:
- 2 banks x 2^(V_BITS+H_BITS) words.
- Word address = {bank, v, h}.

Read path:
- On every clk edge, rd_data <= mem[{front_bank, rd_v, rd_h}] if rd_en=1 and rd_h<H_ACTIVE and rd_v<V_ACTIVE; otherwise rd_data <= 0.
- front_bank is sampled in the same cycle as the address.

FSM:
- IDLE:
  - wr_ready=1.
  - An accepted write with wr_h<H_ACTIVE and wr_v<V_ACTIVE stores wr_data at {~front_bank, wr_v, wr_h}.
  - An out-of-range write still completes the handshake, is dropped, and sets wr_oob (cleared only by reset).
  - clr_req=1 -> go to CLEAR. Latch tgt=~front_bank and clr_color; ch=0, cv=0. clr_req has priority: a write in the same cycle is not accepted (wr_ready is combinational from state and clr_req, so wr_ready=0 that cycle).
- CLEAR:
  - wr_ready=0, clr_busy=1.
  - Each cycle write the colour to {tgt, cv, ch}; ch increments, wraps at H_ACTIVE-1 to 0 and increments cv.
  - After writing (H_ACTIVE-1, V_ACTIVE-1) -> IDLE. clr_busy is high for exactly H_ACTIVE*V_ACTIVE cycles.
  - clr_req while busy is ignored.

Swap:
- swap_req sets swap_pending; repeated requests before the swap merge into one.
- Swap fires on a cycle with frame_end=1 && swap_pending (or swap_req in the same cycle) && FSM=IDLE.
- On a swap: front_bank toggles, swap_pending clears, frame_cnt++ at that edge.
- frame_end while CLEAR: swap is deferred to the next frame_end after the clear completes; the cleared bank is never shown half-filled.
- A write accepted in the swap cycle targets the pre-swap back bank.
- frame_end with no swap pending: no effect.

Reset mid-clear or mid-swap: FSM returns to IDLE immediately and the pending swap is lost.

Test Plan:
All scenarios use H_BITS=3, V_BITS=2, H_ACTIVE=6, V_ACTIVE=3, PIX_W=8.
1. Reset, write (2,1)=0xA5, swap_req, frame_end -> front_bank=1, frame_cnt=1; next cycle after rd_en=1 with (2,1), rd_data=0xA5; rd_en=0 -> rd_data=0.
2. clr_req with clr_color=0x3C -> clr_busy high exactly 18 cycles, wr_ready=0 throughout; after swap + frame_end, all 18 visible reads return 0x3C.
3. Write (6,0) and (0,3) -> both handshake with wr_ready=1, wr_oob=1, memory unchanged; read (6,0) with rd_en=1 -> 0.
4. swap_req, then frame_end at clear cycle 5 -> no swap, swap_pending=1; first frame_end after clr_busy falls -> front_bank toggles, swap_pending=0.
5. swap_req x3, then frame_end x2 -> single toggle, frame_cnt=+1; wr_valid in the swap cycle writes the old back bank (visible after the swap).
6. Assert resetn=0 mid-clear with swap_pending=1 -> same cycle clr_busy=0, swap_pending=0, front_bank=0, rd_data=0.
